// File: rtl/cpup_pkg.sv
// Shared definitions for the fetch/execute sequencer: state encoding,
// halt opcode default and the opcode field position within an instruction.
package cpup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

  // Opcode field of an instruction word
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  // Fetch timer width; the timer saturates at its maximum value
  localparam int TIMER_W = 8;

endpackage

// File: rtl/instr_sequencer_fetch_timer.sv
// Fetch timeout timer: clear, hold, saturating increment and a
// terminal-count flag that is high when the last allowed wait cycle is reached.
module fetch_timer
  import cpup_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic hold,
  input  logic inc,
  output logic terminal
);

  localparam logic [TIMER_W-1:0] TERM_COUNT = TIMER_W'(FETCH_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] MAX_COUNT  = '1;

  logic [TIMER_W-1:0] count;

  // Counter: clear has priority, hold freezes, increment saturates at all-ones
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold && inc && (count != MAX_COUNT)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TERM_COUNT);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: fetches an instruction word at P over the shared
// bus, latches it into the instruction register, runs the microcode unit
// until end-of-microprogram, and handles paging stalls, fetch timeouts,
// halt opcodes and external run/halt control.
module instr_sequencer
  import cpup_pkg::*;
#(
  parameter int         DATA_W        = 16,
  parameter int         FETCH_TIMEOUT = 15,
  parameter logic [3:0] HALT_OPCODE   = HALT_OPCODE_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] bus,
  input  logic              run,
  input  logic              halt_req,
  input  logic              paging,
  input  logic              mem_ready,
  input  logic              exec_done,
  output logic              pc_oe,
  output logic              pc_inc,
  output logic              mem_rd,
  output logic              exec_en,
  output logic [DATA_W-1:0] instruction,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        state
);

  if ((FETCH_TIMEOUT < 1) || (FETCH_TIMEOUT > 255)) begin : g_bad_timeout
    $error("instr_sequencer: FETCH_TIMEOUT must be in 1..255");
  end
  if (DATA_W <= OPC_MSB) begin : g_bad_width
    $error("instr_sequencer: DATA_W too narrow for the opcode field");
  end

  state_t            state_q;
  state_t            state_d;
  logic              run_q;
  logic              run_rise;
  logic              fault_q;
  logic [DATA_W-1:0] instr_q;

  logic              timer_clear;
  logic              timer_hold;
  logic              timer_inc;
  logic              timer_term;
  logic              load_instr;
  logic              set_fault;
  logic              is_halt_op;

  assign run_rise   = run & ~run_q;
  assign is_halt_op = (instr_q[OPC_MSB:OPC_LSB] == HALT_OPCODE);

  fetch_timer #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetch_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .hold    (timer_hold),
    .inc     (timer_inc),
    .terminal(timer_term)
  );

  // Next-state logic and timer/latch control
  always_comb begin
    state_d     = state_q;
    timer_clear = 1'b0;
    timer_hold  = 1'b0;
    timer_inc   = 1'b0;
    load_instr  = 1'b0;
    set_fault   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_rise) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        timer_clear = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // An MMU stall freezes the fetch even when data is already valid
        if (paging) begin
          timer_hold = 1'b1;
        end else if (mem_ready) begin
          load_instr = 1'b1;
          state_d    = ST_EXEC;
        end else if (timer_term) begin
          set_fault = 1'b1;
          state_d   = ST_FAULT;
        end else begin
          timer_inc = 1'b1;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          if (is_halt_op || halt_req) state_d = ST_HALTED;
          else                        state_d = ST_FETCH;
        end
      end
      ST_HALTED: begin
        if (run_rise) state_d = ST_FETCH;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, run edge detector and sticky fault flag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run;
      if (set_fault) fault_q <= 1'b1;
    end
  end

  // Instruction register, loaded when fetched data is accepted
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      instr_q <= '0;
    end else if (load_instr) begin
      instr_q <= bus;
    end
  end

  assign pc_oe       = (state_q == ST_FETCH) || (state_q == ST_WAIT);
  assign mem_rd      = pc_oe;
  assign pc_inc      = (state_q == ST_WAIT) && mem_ready && !paging;
  assign exec_en     = (state_q == ST_EXEC);
  assign halted      = (state_q == ST_HALTED);
  assign fault       = fault_q;
  assign instruction = instr_q;
  assign state       = state_q;

endmodule
